clk_div_ctrl: RTL and testbench
===============================

CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all logic on posedge clk.
REQ-002 SHALL have port rst, input, 1, reset: synchronous, active-low.
REQ-003 SHALL have port en, input, 1, level enable for divided clock generation.
REQ-004 SHALL have port div_req, input, 1, single-cycle request to load a new divide ratio.
REQ-005 SHALL have port div_val, input, 8, requested ratio N, sampled only when div_req=1.
REQ-006 SHALL have port div_ack, output, 1, one-cycle pulse when the requested ratio takes effect.
REQ-007 SHALL have port div_err, output, 1, one-cycle pulse when a request is rejected.
REQ-008 SHALL have port busy, output, 1, high while an accepted ratio is pending.
REQ-009 SHALL have port clk_out, output, 1, registered divided clock.
REQ-010 SHALL have port tick, output, 1, one-cycle strobe coinciding with each clk_out rising period start.
REQ-011 SHALL have port state, output, 2, FSM state (IDLE=0, RUN=1, STOP=2).

Function
REQ-012 SHALL hold active ratio N (8 bit) and period counter cnt (8 bit); H = N>>1; in RUN/STOP, clk_out=1 when cnt<H, else 0.
REQ-013 SHALL wrap cnt from N-1 to 0; a cycle with cnt=0 is a period start and SHALL assert tick.
REQ-014 IDLE: clk_out=0, tick=0, cnt=0; en=1 SHALL move to RUN next cycle, with cnt=0, clk_out=1 and tick=1 in that first RUN cycle.
REQ-015 RUN: en=0 SHALL move to STOP; current period SHALL complete; IDLE is entered in the cycle after cnt=N-1.
REQ-016 STOP: en=1 before the period ends SHALL return to RUN without truncating or gapping the period; the next period starts on schedule.
REQ-017 Valid request: div_req=1 with 2<=div_val<=255 and busy=0; invalid: div_val<2, or busy=1.
REQ-018 Invalid requests SHALL pulse div_err in the cycle after div_req and SHALL NOT change N, pending value or busy.
REQ-019 Valid request in RUN/STOP SHALL store div_val as pending and set busy the next cycle; N SHALL update at the next period boundary, and the first cycle with cnt=0 under the new N SHALL pulse div_ack and clear busy.
REQ-020 Valid request in IDLE SHALL update N the next cycle, pulse div_ack that cycle, and leave busy=0.
REQ-021 If a pending ratio exists when STOP enters IDLE, N SHALL update and div_ack SHALL pulse in the first IDLE cycle.
REQ-022 Simultaneous en change and valid div_req SHALL both be honoured per REQ-014..REQ-021; neither is dropped.
REQ-023 clk_out SHALL never show a high or low phase shorter than the phase lengths of the ratios in effect (no glitches on ratio change or stop).
REQ-024 Odd N: high phase H cycles, low phase N-H cycles (for example, N=5 gives 2 high and 3 low).

Reset
REQ-025 While rst=0 at posedge clk: state=IDLE, N=4, pending cleared, cnt=0, clk_out=0, tick=0, div_ack=0, div_err=0, busy=0.
REQ-026 Reset mid-operation (any state, pending or not) SHALL abandon the current period and pending request immediately, with no ack or err issued.

Verification
REQ-027 Reset, en=1 -> clk_out repeats 1,1,0,0 (N=4), tick every 4th cycle starting in the first RUN cycle.
REQ-028 Running N=4, request div_val=6 at cnt=1 -> busy=1 next cycle; period completes at 4; next period has 3 high and 3 low cycles; div_ack coincides with its tick.
REQ-029 IDLE, request div_val=5, then en=1 -> ack in the cycle after req; clk_out runs 2 high and 3 low repeatedly.
REQ-030 Requests div_val=0, div_val=1, and a second valid request while busy=1 -> div_err pulse each time; N unchanged; no div_ack.
REQ-031 N=8, drop en at cnt=2 -> full 8-cycle period completes, then IDLE with clk_out=0; re-assert en at cnt=6 in STOP -> next period starts at cnt=0 seamlessly.
REQ-032 rst=0 asserted in RUN with pending request -> all outputs zero the next cycle, N=4, busy=0, no div_ack.

Source files
------------

// File: rtl/clk_div_ctrl.sv
// Programmable clock divider: registered clk_out/tick from a period counter,
// with glitch-free ratio changes applied on period boundaries and graceful stop.
module clk_div_ctrl #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              div_req,
  input  logic [DATA_W-1:0] div_val,
  output logic              div_ack,
  output logic              div_err,
  output logic              busy,
  output logic              clk_out,
  output logic              tick,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t            st, st_nxt;
  logic [DATA_W-1:0] n, n_nxt;
  logic [DATA_W-1:0] pend, pend_nxt;
  logic [DATA_W-1:0] cnt, cnt_nxt;
  logic              busy_nxt, ack_nxt, err_nxt, clk_nxt, tick_nxt;
  logic              req_ok, last;

  always_ff @(posedge clk) begin
    if (!rst) begin
      st      <= IDLE;
      n       <= DATA_W'(4);
      pend    <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      div_ack <= 1'b0;
      div_err <= 1'b0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      st      <= st_nxt;
      n       <= n_nxt;
      pend    <= pend_nxt;
      cnt     <= cnt_nxt;
      busy    <= busy_nxt;
      div_ack <= ack_nxt;
      div_err <= err_nxt;
      clk_out <= clk_nxt;
      tick    <= tick_nxt;
    end
  end

  always_comb begin
    req_ok   = div_req && (div_val >= DATA_W'(2)) && !busy;
    last     = (cnt >= n - DATA_W'(1));
    st_nxt   = st;
    n_nxt    = n;
    pend_nxt = pend;
    cnt_nxt  = cnt;
    busy_nxt = busy;
    ack_nxt  = 1'b0;
    err_nxt  = div_req && !req_ok;

    case (st)
      IDLE: begin
        cnt_nxt = '0;
        if (en) st_nxt = RUN;
      end
      RUN: begin
        cnt_nxt = last ? '0 : cnt + DATA_W'(1);
        if (!en) st_nxt = last ? IDLE : STOP;
      end
      STOP: begin
        cnt_nxt = last ? '0 : cnt + DATA_W'(1);
        if (en)        st_nxt = RUN;
        else if (last) st_nxt = IDLE;
      end
      default: begin
        st_nxt  = IDLE;
        cnt_nxt = '0;
      end
    endcase

    // A pending ratio is swapped in only at a period boundary, so no phase is cut short
    if (st != IDLE && last && busy) begin
      n_nxt    = pend;
      busy_nxt = 1'b0;
      ack_nxt  = 1'b1;
    end

    // With no period running (now or from the next cycle) a new ratio can apply at once
    if (req_ok) begin
      if (st == IDLE || st_nxt == IDLE) begin
        n_nxt   = div_val;
        ack_nxt = 1'b1;
      end else begin
        pend_nxt = div_val;
        busy_nxt = 1'b1;
      end
    end

    clk_nxt  = (st_nxt != IDLE) && (cnt_nxt < (n_nxt >> 1));
    tick_nxt = (st_nxt != IDLE) && (cnt_nxt == '0);
  end

  assign state = st;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: each step drives inputs, queues the expected
// registered outputs for the following edge, then pops and compares them.
module tb_clk_div_ctrl;

  logic       clk;
  logic       rst;
  logic       en;
  logic       div_req;
  logic [7:0] div_val;
  logic       div_ack, div_err, busy, clk_out, tick;
  logic [1:0] state;

  localparam logic [1:0] I = 2'd0, R = 2'd1, S = 2'd2;

  typedef struct {
    string      tag;
    logic [6:0] v;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  clk_div_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .div_req (div_req),
    .div_val (div_val),
    .div_ack (div_ack),
    .div_err (div_err),
    .busy    (busy),
    .clk_out (clk_out),
    .tick    (tick),
    .state   (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [6:0] ex(logic c, logic t, logic a, logic e, logic b, logic [1:0] s);
    return {c, t, a, e, b, s};
  endfunction

  // Expected outputs at position i of a free-running divide-by-nr sequence
  function automatic logic [6:0] pat(int nr, int i, logic [1:0] s);
    int k;
    k = i % nr;
    return ex(k < nr / 2, k == 0, 1'b0, 1'b0, 1'b0, s);
  endfunction

  task automatic step(input logic e, input logic r, input logic [7:0] v,
                      input string tag, input logic [6:0] expv);
    exp_t it;
    logic [6:0] obs;
    en      = e;
    div_req = r;
    div_val = v;
    it.tag  = tag;
    it.v    = expv;
    q.push_back(it);
    @(posedge clk);
    #1;
    it  = q.pop_front();
    obs = {clk_out, tick, div_ack, div_err, busy, state};
    n_chk++;
    assert (obs === it.v) else begin
      n_fail++;
      $error("FAIL %s: observed {clk_out,tick,ack,err,busy,state}=%b expected %b", it.tag, obs, it.v);
    end
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; div_req = 1'b0; div_val = 8'd0;

    // Reset dominates even with active inputs
    step(1'b0, 1'b0, 8'd0, "rst0", ex(0, 0, 0, 0, 0, I));
    step(1'b1, 1'b1, 8'd6, "rst1", ex(0, 0, 0, 0, 0, I));
    rst = 1'b1;

    // Default N=4: 1,1,0,0 with tick every 4th cycle
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'd0, "n4_run", pat(4, i, R));

    // Request 6 at cnt=1: busy, finish current period, ack on first tick of N=6
    step(1'b1, 1'b1, 8'd6, "req6",   ex(0, 0, 0, 0, 1, R));
    step(1'b1, 1'b0, 8'd0, "busy6",  ex(0, 0, 0, 0, 1, R));
    step(1'b1, 1'b0, 8'd0, "ack6",   ex(1, 1, 1, 0, 0, R));
    for (int i = 1; i <= 6; i++) step(1'b1, 1'b0, 8'd0, "n6_run", pat(6, i, R));

    // Rejected requests: 0, 1, and one while busy
    step(1'b1, 1'b1, 8'd0, "err_val0", ex(1, 0, 0, 1, 0, R));
    step(1'b1, 1'b1, 8'd1, "err_val1", ex(1, 0, 0, 1, 0, R));
    step(1'b1, 1'b1, 8'd9, "req9",     ex(0, 0, 0, 0, 1, R));
    step(1'b1, 1'b1, 8'd7, "err_busy", ex(0, 0, 0, 1, 1, R));
    step(1'b1, 1'b0, 8'd0, "busy9",    ex(0, 0, 0, 0, 1, R));
    step(1'b1, 1'b0, 8'd0, "ack9",     ex(1, 1, 1, 0, 0, R));
    for (int i = 1; i <= 9; i++) step(1'b1, 1'b0, 8'd0, "n9_run", pat(9, i, R));

    // Drop en at period start: full odd period completes in STOP, then IDLE
    for (int i = 1; i <= 8; i++) step(1'b0, 1'b0, 8'd0, "n9_stop", pat(9, i, S));
    step(1'b0, 1'b0, 8'd0, "idle_a", ex(0, 0, 0, 0, 0, I));
    step(1'b0, 1'b0, 8'd0, "idle_b", ex(0, 0, 0, 0, 0, I));

    // Request in IDLE acks next cycle without busy
    step(1'b0, 1'b1, 8'd8, "idle_req8", ex(0, 0, 1, 0, 0, I));

    // N=8: drop en at cnt=2, re-assert at cnt=6 in STOP, period continues seamlessly
    step(1'b1, 1'b0, 8'd0, "n8_c0", pat(8, 0, R));
    step(1'b1, 1'b0, 8'd0, "n8_c1", pat(8, 1, R));
    step(1'b1, 1'b0, 8'd0, "n8_c2", pat(8, 2, R));
    for (int i = 3; i <= 6; i++) step(1'b0, 1'b0, 8'd0, "n8_stop", pat(8, i, S));
    for (int i = 7; i <= 16; i++) step(1'b1, 1'b0, 8'd0, "n8_resume", pat(8, i, R));

    // Reset in RUN with a pending ratio: abandoned, no ack, N back to 4
    step(1'b1, 1'b1, 8'd3, "req3", ex(1, 0, 0, 0, 1, R));
    rst = 1'b0;
    step(1'b1, 1'b0, 8'd0, "rst_mid",  ex(0, 0, 0, 0, 0, I));
    rst = 1'b1;
    step(1'b0, 1'b0, 8'd0, "post_rst", ex(0, 0, 0, 0, 0, I));
    for (int i = 0; i <= 4; i++) step(1'b1, 1'b0, 8'd0, "n4_after_rst", pat(4, i, R));

    // Simultaneous en and valid request from IDLE: both honoured, N=5 gives 2 high/3 low
    rst = 1'b0;
    step(1'b0, 1'b0, 8'd0, "rst_again", ex(0, 0, 0, 0, 0, I));
    rst = 1'b1;
    step(1'b1, 1'b1, 8'd5, "en_req5", ex(1, 1, 1, 0, 0, R));
    for (int i = 1; i <= 14; i++) step(1'b1, 1'b0, 8'd0, "n5_run", pat(5, i, R));

    // en dropped on the last cycle of a period in RUN goes straight to IDLE
    step(1'b0, 1'b0, 8'd0, "run_last_stop", ex(0, 0, 0, 0, 0, I));
    step(1'b0, 1'b0, 8'd0, "idle_hold",     ex(0, 0, 0, 0, 0, I));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
